// File: rtl/sound_fx.sv
`default_nettype none
// ============================================================================
//  Module   : sound_fx
//  Purpose  : Plays square-wave note sequences for eat/fail/win game events.
//  Revision : 1.0 - initial release
// ============================================================================
module sound_fx #(
   parameter int NOTE_CYCLES = 2097152,
   parameter int HP_SHIFT    = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_eat,
   input  logic i_failure,
   input  logic i_success,
   input  logic i_mute,
   output logic o_audio,
   output logic o_busy
);

   localparam int            DW       = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
   localparam logic [DW-1:0] DUR_LAST = DW'(NOTE_CYCLES - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_t;
   typedef enum logic [1:0] {FX_EAT = 2'd0, FX_FAIL = 2'd1, FX_WIN = 2'd2} fx_t;

   state_t        state_q, state_d;
   fx_t           fx_q, fx_d;
   logic [1:0]    note_q, note_d;
   logic [DW-1:0] dur_q, dur_d;
   logic [15:0]   tone_q, tone_d;
   logic          audio_q, audio_d;
   logic          fail_prev_q, succ_prev_q;

   logic [15:0]   hp_raw, hp_shift, hp;
   logic [1:0]    last_note;
   logic          fail_rise, succ_rise, eat_ok, start;
   fx_t           start_fx;

   // Half-period table for the note currently playing
   always_comb begin
      hp_raw    = 16'd2;
      last_note = 2'd0;
      case (fx_q)
         FX_EAT: begin
            last_note = 2'd1;
            hp_raw    = (note_q == 2'd0) ? 16'd9547 : 16'd8028;
         end
         FX_FAIL: begin
            last_note = 2'd2;
            case (note_q)
               2'd0:    hp_raw = 16'd24056;
               2'd1:    hp_raw = 16'd28608;
               default: hp_raw = 16'd38188;
            endcase
         end
         FX_WIN: begin
            last_note = 2'd3;
            case (note_q)
               2'd0:    hp_raw = 16'd12028;
               2'd1:    hp_raw = 16'd9547;
               2'd2:    hp_raw = 16'd8028;
               default: hp_raw = 16'd6014;
            endcase
         end
         default: begin
            last_note = 2'd0;
            hp_raw    = 16'd2;
         end
      endcase
      hp_shift = hp_raw >> HP_SHIFT;
      hp       = (hp_shift < 16'd2) ? 16'd2 : hp_shift;
   end

   // Trigger arbitration: FAIL > WIN > EAT; EAT only restarts an EAT effect
   always_comb begin
      fail_rise = i_failure & ~fail_prev_q;
      succ_rise = i_success & ~succ_prev_q;
      eat_ok    = i_eat & ((state_q == ST_IDLE) | (fx_q == FX_EAT));
      start     = fail_rise | succ_rise | eat_ok;
      start_fx  = FX_EAT;
      if (fail_rise) begin
         start_fx = FX_FAIL;
      end else if (succ_rise) begin
         start_fx = FX_WIN;
      end
   end

   always_comb begin
      state_d = state_q;
      fx_d    = fx_q;
      note_d  = note_q;
      dur_d   = dur_q;
      tone_d  = tone_q;
      audio_d = audio_q;
      if (start) begin
         state_d = ST_PLAY;
         fx_d    = start_fx;
         note_d  = 2'd0;
         dur_d   = '0;
         tone_d  = 16'd0;
         audio_d = 1'b0;
      end else if (state_q == ST_PLAY) begin
         // Note boundary wins over a coincident tone toggle
         if (dur_q == DUR_LAST) begin
            dur_d   = '0;
            tone_d  = 16'd0;
            audio_d = 1'b0;
            if (note_q == last_note) begin
               state_d = ST_IDLE;
               note_d  = 2'd0;
            end else begin
               note_d = note_q + 2'd1;
            end
         end else begin
            dur_d = dur_q + DW'(1);
            if (tone_q == hp - 16'd1) begin
               audio_d = ~audio_q;
               tone_d  = 16'd0;
            end else begin
               tone_d = tone_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fx_q        <= FX_EAT;
         note_q      <= 2'd0;
         dur_q       <= '0;
         tone_q      <= 16'd0;
         audio_q     <= 1'b0;
         fail_prev_q <= 1'b0;
         succ_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fx_q        <= fx_d;
         note_q      <= note_d;
         dur_q       <= dur_d;
         tone_q      <= tone_d;
         audio_q     <= audio_d;
         fail_prev_q <= i_failure;
         succ_prev_q <= i_success;
      end
   end

   assign o_busy  = (state_q == ST_PLAY);
   assign o_audio = audio_q & ~i_mute;

endmodule
`default_nettype wire

// File: tb/tb_sound_fx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sound_fx
//  Purpose  : Directed + random bench for sound_fx against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sound_fx;

   localparam int N  = 256;
   localparam int SH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_eat = 1'b0;
   logic i_failure = 1'b0;
   logic i_success = 1'b0;
   logic i_mute = 1'b0;
   logic o_audio;
   logic o_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sound_fx #(.NOTE_CYCLES(N), .HP_SHIFT(SH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_eat     (i_eat),
      .i_failure (i_failure),
      .i_success (i_success),
      .i_mute    (i_mute),
      .o_audio   (o_audio),
      .o_busy    (o_busy)
   );

   // Model: effect id (0 eat, 1 fail, 2 win) and cycles elapsed since trigger
   bit m_busy = 1'b0;
   int m_fx   = 0;
   int m_t    = 0;
   bit m_fp   = 1'b0;
   bit m_sp   = 1'b0;

   function automatic int tbl(input int fx, input int idx);
      int v;
      if (fx == 0)      v = (idx == 0) ? 9547 : 8028;
      else if (fx == 1) v = (idx == 0) ? 24056 : (idx == 1) ? 28608 : 38188;
      else              v = (idx == 0) ? 12028 : (idx == 1) ? 9547 : (idx == 2) ? 8028 : 6014;
      return v;
   endfunction

   function automatic int hp_of(input int fx, input int idx);
      int h;
      h = tbl(fx, idx) / (1 << SH);
      return (h < 2) ? 2 : h;
   endfunction

   function automatic bit exp_audio();
      if (!m_busy) return 1'b0;
      return (((m_t % N) / hp_of(m_fx, m_t / N)) % 2) == 1;
   endfunction

   task automatic model_edge();
      bit fr, sr;
      if (!rst_n) begin
         m_busy = 1'b0; m_t = 0; m_fp = 1'b0; m_sp = 1'b0;
      end else begin
         fr = i_failure && !m_fp;
         sr = i_success && !m_sp;
         m_fp = i_failure;
         m_sp = i_success;
         if (fr || sr || (i_eat && (!m_busy || m_fx == 0))) begin
            m_fx   = fr ? 1 : sr ? 2 : 0;
            m_busy = 1'b1;
            m_t    = 0;
         end else if (m_busy) begin
            m_t++;
            if (m_t >= (m_fx + 2) * N) begin
               m_busy = 1'b0;
               m_t    = 0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("busy", {31'd0, o_busy}, {31'd0, m_busy});
      chk("audio", {31'd0, o_audio}, {31'd0, exp_audio() & !i_mute});
   endtask

   // Runs n cycles, counting busy cycles and the first cycle o_audio is high
   task automatic run_meas(input int n, output int cnt, output int first);
      cnt   = 0;
      first = -1;
      for (int j = 1; j <= n; j++) begin
         tick();
         if (o_busy) cnt++;
         if (first < 0 && o_audio) first = j;
      end
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) tick();
   endtask

   int cnt, first, c0;

   initial begin
      // Reset, then idle with all inputs low
      run(5);
      rst_n = 1'b1;
      run(1000);
      chk("idle_busy", {31'd0, o_busy}, 32'd0);

      // Single eat pulse
      i_eat = 1'b1; tick(); c0 = o_busy; i_eat = 1'b0;
      run_meas(600, cnt, first);
      chk("eat_len", cnt + c0, 512);
      chk("eat_rise", first, 37);

      // Failure level held for 2000 cycles, eat at +300 ignored
      i_failure = 1'b1; tick(); c0 = o_busy;
      cnt = 0;
      for (int j = 1; j < 2000; j++) begin
         if (j == 300) i_eat = 1'b1;
         tick();
         i_eat = 1'b0;
         if (o_busy) cnt++;
      end
      chk("fail_len", cnt + c0, 768);
      i_failure = 1'b0;
      run(10);

      // Eat then success 100 cycles later: WIN preempts
      i_eat = 1'b1; tick(); i_eat = 1'b0;
      run(99);
      i_success = 1'b1; tick(); c0 = o_busy;
      run_meas(1100, cnt, first);
      chk("win_len", cnt + c0, 1024);
      chk("win_rise", first, 46);
      i_success = 1'b0;
      run(5);

      // Simultaneous fail + success + eat: FAIL wins
      i_failure = 1'b1; i_success = 1'b1; i_eat = 1'b1; tick(); c0 = o_busy; i_eat = 1'b0;
      run_meas(900, cnt, first);
      chk("prio_len", cnt + c0, 768);
      chk("prio_rise", first, 93);
      i_failure = 1'b0; i_success = 1'b0;
      run(5);

      // Mute toggled mid-WIN
      i_success = 1'b1; tick();
      for (int j = 1; j < 1100; j++) begin
         i_mute = ((j >= 300 && j < 500) || (j >= 700 && j < 750));
         tick();
      end
      i_mute = 1'b0; i_success = 1'b0;
      run(5);

      // Reset mid-FAIL
      i_failure = 1'b1; tick();
      run(200);
      rst_n = 1'b0; tick();
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_audio", {31'd0, o_audio}, 32'd0);
      rst_n = 1'b1;
      run(800);
      i_failure = 1'b0;
      run(5);

      // Random traffic
      for (int j = 0; j < 4000; j++) begin
         i_eat = ($urandom % 150) == 0;
         if (($urandom % 700) == 0) i_failure = ~i_failure;
         if (($urandom % 700) == 0) i_success = ~i_success;
         if (($urandom % 60) == 0)  i_mute = ~i_mute;
         rst_n = ($urandom % 3000) != 0;
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sound_fx.md
Name: sound_fx

Overview:
Audio effects generator directly downstream of the game top level. It consumes the game's o_eat pulse and its sticky o_failure / o_success levels, and plays short square-wave note sequences on a 1-bit piezo/speaker pin. It runs on the same clk as the game and VGA (25.175 MHz pixel clock). The note table below is tuned to that clock.

Parameters:
NOTE_CYCLES, 2097152, length of each note in clk cycles (about 83 ms); must be >= 2
HP_SHIFT, 0, right-shift applied to every table half-period (simulation speed-up); the effective half-period is clamped to a minimum of 2

Ports:
clk  input  1  clock (game/VGA pixel clock)
rst_n  input  1  synchronous active-low reset
i_eat  input  1  one-cycle pulse when the snake eats an apple
i_failure  input  1  game failure level; stays high until restart
i_success  input  1  game success level; stays high until restart
i_mute  input  1  forces o_audio low; sequencing continues
o_audio  output  1  square-wave audio output
o_busy  output  1  high while an effect is playing

Behaviour:
- Reset is rst_n, synchronous, active-low, on clock clk.
- Reset values: state=IDLE, o_busy=0, o_audio=0, note_idx=0, dur_cnt=0, tone_cnt=0, audio_q=0, fail_prev=0, succ_prev=0.
- Edge detection: fail_rise = i_failure & !fail_prev; succ_rise = i_success & !succ_prev. fail_prev and succ_prev follow the inputs every cycle. A held level therefore triggers exactly once. i_eat is used as a level-1 pulse with no edge detection.
- Effect table (half-periods in cycles before shift):
  - EAT: 9547 (E6), 8028 (G6).
  - FAIL: 24056 (C5), 28608 (A4), 38188 (E4).
  - WIN: 12028 (C6), 9547 (E6), 8028 (G6), 6014 (C7).
  - hp = max(table >> HP_SHIFT, 2).
- Trigger priority within one cycle: FAIL > WIN > EAT.
- Trigger acceptance:
  - In IDLE, any trigger is accepted.
  - In PLAY, FAIL or WIN preempts any effect, including itself.
  - EAT is accepted only if the current effect is EAT, in which case it restarts from note 0. EAT is ignored during FAIL or WIN.
- On an accepted trigger at edge k: state=PLAY, effect latched, note_idx=0, dur_cnt=0, tone_cnt=0, audio_q=0. o_busy=1 is visible after edge k.
- Each cycle in PLAY:
  - Tone: if tone_cnt == hp-1, then audio_q toggles and tone_cnt=0; else tone_cnt++. The first rising edge of o_audio occurs exactly hp cycles after o_busy rises.
  - Duration: if dur_cnt == NOTE_CYCLES-1:
    - If this is the last note of the effect: state=IDLE, audio_q=0, counters=0.
    - Otherwise: note_idx++, dur_cnt=0, tone_cnt=0, audio_q=0.
  - Otherwise dur_cnt++.
  - Duration handling takes priority over the tone toggle in the same cycle.
- Effect lengths: EAT = 2*NOTE_CYCLES, FAIL = 3*NOTE_CYCLES, WIN = 4*NOTE_CYCLES cycles of o_busy=1.
- o_audio = audio_q & !i_mute. This is the only combinational path, and o_audio is glitch-free with respect to audio_q.
- o_busy = (state == PLAY), registered.
- A failing level dropping (game restart) does not stop an effect in progress. A new rising edge retriggers.
- Reset mid-effect returns to IDLE with o_audio=0 on the next edge.
- Width rules: dur_cnt is $clog2(NOTE_CYCLES) bits; tone_cnt and hp are 16 bits. All table values fit in 16 bits.

Test Plan:
(Bench uses NOTE_CYCLES=256 and HP_SHIFT=8, giving EAT hp 37/31, FAIL hp 93/111/149, WIN hp 46/37/31/23.)
- Reset with all inputs low for 1000 cycles -> o_busy=0 and o_audio=0 throughout.
- Single i_eat pulse at edge k:
  - o_busy=1 for exactly 512 cycles.
  - o_audio first rises at k+37 and toggles every 37 cycles until k+256, then every 31 cycles.
  - o_audio=0 after k+512.
- i_failure held high for 2000 cycles -> exactly one FAIL effect of 768 cycles with half-periods 93/111/149 and no retrigger. An i_eat pulse at k+300 is ignored.
- i_eat followed 100 cycles later by i_success rising -> WIN preempts: note_idx=0 with hp 46 from that edge, and o_busy stays high for 1024 further cycles.
- i_failure and i_success rising in the same cycle together with i_eat -> FAIL is played.
- i_mute toggled mid-WIN -> o_audio=0 while muted; after unmute the waveform phase matches the unmuted reference. Asserting rst_n=0 mid-FAIL -> o_busy=0 and o_audio=0 on the next edge.
